lcd_datapath: RTL and testbench
===============================

Name: lcd_datapath

Overview:
- Datapath stage directly downstream of LCD_controller.
- Consumes data_sel, DB_sel, init_sel, mux_sel, E_out, RW_out and RS_out, and produces the 8-bit LCD DB bus.
- Holds a 32-character display buffer (2 lines x 16) that the user logic writes, a display-position pointer, and the init command constants.
- Also reports line-wrap and frame-done events back to the controller.

Parameters:
- INIT_FUNC, 8'h38, function-set command (8-bit bus, 2 lines, 5x8 font).
- INIT_DISP, 8'h0C, display on, cursor off.
- INIT_ENTRY, 8'h06, entry mode: increment, no shift.
- INIT_CLEAR, 8'h01, clear-display command.
- FILL_CHAR, 8'h20, buffer content after reset (ASCII space).

Ports:
- clk_1ms  in  1  system clock, shared with LCD_controller.
- reset  in  1  asynchronous, active-low reset.
- data_sel  in  1  from controller; 1 = current transfer is a character-data write.
- DB_sel  in  1  from controller; 1 = drive DB, 0 = release.
- init_sel  in  2  from controller; init command index.
- mux_sel  in  2  from controller; DB source select.
- E_out  in  1  from controller; LCD enable strobe.
- RW_out  in  1  from controller; 1 = read cycle.
- RS_out  in  1  from controller; 1 = data register.
- wr_en  in  1  user buffer write strobe.
- wr_addr  in  5  user buffer address: 0-15 line 1, 16-31 line 2.
- wr_data  in  8  user character code.
- DB_in  in  8  LCD bus readback. Used only when LCD_BUSY_READ_EN is defined.
- DB_out  out  8  registered LCD bus value.
- DB_oe  out  1  bus output enable, for the tri-state in the top level.
- char_ptr  out  5  current display position.
- line_wrap  out  1  one-cycle pulse when char_ptr advances 15->16 or 31->0.
- frame_done  out  1  one-cycle pulse when char_ptr advances 31->0.
- busy  out  1  LCD busy flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - DB_out=8'h00, DB_oe=0, char_ptr=0, line_wrap=0, frame_done=0, busy=0.
  - All 32 buffer entries = FILL_CHAR.
  - E_out edge-detect register = 0.
- Buffer write:
  - Synchronous on the rising clk_1ms edge when wr_en=1.
  - All 5 address bits are significant, so there is no out-of-range case.
- Source mux, registered; DB_out updates on the clock edge after the selects change (1-cycle latency):
  - mux_sel=0: init constant by init_sel (0 INIT_FUNC, 1 INIT_DISP, 2 INIT_ENTRY, 3 INIT_CLEAR).
  - mux_sel=1: set-DDRAM-address command = 8'h80 | {char_ptr[4], 2'b00, char_ptr[3:0]}, i.e. 0x80-0x8F or 0xC0-0xCF.
  - mux_sel=2: buffer[char_ptr].
  - mux_sel=3: INIT_CLEAR.
- DB_oe: registered, = DB_sel & ~RW_out, with the same 1-cycle latency as DB_out.
- Pointer advance:
  - E falling edge detected as registered E_out=1 and current E_out=0.
  - On that cycle, if data_sel=1, RS_out=1 and RW_out=0, char_ptr increments modulo 32.
  - E falls with mux_sel=3 (clear) and RS_out=0: char_ptr resets to 0 and no wrap pulse is generated.
- Wrap outputs: line_wrap and frame_done are registered and high for exactly the one cycle after the advancing edge. frame_done implies line_wrap.
- Simultaneous user write to buffer[char_ptr] while mux_sel=2:
  - DB_out captures the old data on that edge.
  - The new data appears on the next edge.
- Reset mid-transfer: all state returns to reset values immediately; DB_oe drops without waiting for the clock.
- Controller timing requirement: selects must be stable at least 1 clk_1ms cycle before E_out rises. This block adds no further delay.

Optional Feature:
- LCD_BUSY_READ_EN defined:
  - When RW_out=1 and RS_out=0, DB_oe is forced 0.
  - busy is registered from DB_in[7] on every cycle in which E_out=1 and RW_out=1. It holds otherwise.
  - busy clears to 0 on reset.
- Undefined:
  - DB_in is ignored and busy is constant 0.
  - RW_out affects only DB_oe as specified above.

Test Plan:
- Release reset -> DB_out=00, DB_oe=0, char_ptr=0. Then mux_sel=2 -> DB_out=8'h20 after 1 clock.
- mux_sel=0 with init_sel 0..3 and DB_sel=1 -> DB_out 38, 0C, 06, 01 on successive cycles, DB_oe=1, each 1 clock after its select.
- Write "A" (8'h41) to addr 16; set char_ptr=16 via 16 data strobes; mux_sel=1 -> DB_out=8'hC0; mux_sel=2 -> DB_out=8'h41.
- 32 E pulses with data_sel=1, RS_out=1 -> line_wrap pulses after pulses 16 and 32, frame_done only after pulse 32, char_ptr back to 0.
- wr_en to addr=char_ptr with mux_sel=2 on the same edge -> old value for 1 cycle, then new. Assert reset low mid-E pulse -> all outputs reset asynchronously.
- With LCD_BUSY_READ_EN: RW_out=1, RS_out=0, E_out=1, DB_in=8'h80 -> busy=1 and DB_oe=0. Then DB_in=8'h00 -> busy=0 on the next clock.

Source files
------------

// File: rtl/lcd_datapath_if.sv
// Bus between LCD_controller / user logic and the lcd_datapath stage.
// The master side drives selects, strobes and buffer writes; the slave side is the datapath.
interface lcd_datapath_if;
    logic       data_sel;
    logic       DB_sel;
    logic [1:0] init_sel;
    logic [1:0] mux_sel;
    logic       E_out;
    logic       RW_out;
    logic       RS_out;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] DB_in;
    logic [7:0] DB_out;
    logic       DB_oe;
    logic [4:0] char_ptr;
    logic       line_wrap;
    logic       frame_done;
    logic       busy;

    modport master (
        output data_sel, DB_sel, init_sel, mux_sel, E_out, RW_out, RS_out,
        output wr_en, wr_addr, wr_data, DB_in,
        input  DB_out, DB_oe, char_ptr, line_wrap, frame_done, busy
    );

    modport slave (
        input  data_sel, DB_sel, init_sel, mux_sel, E_out, RW_out, RS_out,
        input  wr_en, wr_addr, wr_data, DB_in,
        output DB_out, DB_oe, char_ptr, line_wrap, frame_done, busy
    );
endinterface

// File: rtl/lcd_datapath.sv
// LCD DB-bus datapath: 32-char display buffer, position pointer, init constants, wrap events.
// Optional busy-flag readback is enabled by defining LCD_BUSY_READ_EN.
module lcd_datapath #(
    parameter logic [7:0] INIT_FUNC  = 8'h38,
    parameter logic [7:0] INIT_DISP  = 8'h0C,
    parameter logic [7:0] INIT_ENTRY = 8'h06,
    parameter logic [7:0] INIT_CLEAR = 8'h01,
    parameter logic [7:0] FILL_CHAR  = 8'h20
) (
    input  logic          clk_1ms,
    input  logic          reset,
    lcd_datapath_if.slave bus
);

    logic [7:0] buffer_q [32];
    logic [4:0] charPtr_q, charPtr_d;
    logic       eOut_q;
    logic [7:0] dbOut_q, dbOut_d;
    logic       dbOe_q, dbOe_d;
    logic       lineWrap_q, lineWrap_d;
    logic       frameDone_q, frameDone_d;
    logic       busy_q, busy_d;
    logic       eFall;
    logic       advance;
    logic       clearPtr;
    logic [7:0] ddramCmd;

    assign eFall    = eOut_q & ~bus.E_out;
    assign advance  = eFall & bus.data_sel & bus.RS_out & ~bus.RW_out;
    assign clearPtr = eFall & (bus.mux_sel == 2'd3) & ~bus.RS_out;
    // Line 2 of the display starts at DDRAM address 0x40.
    assign ddramCmd = 8'h80 | {1'b0, charPtr_q[4], 2'b00, charPtr_q[3:0]};

    always_comb begin
        dbOut_d = INIT_CLEAR;
        case (bus.mux_sel)
            2'd0: begin
                case (bus.init_sel)
                    2'd0:    dbOut_d = INIT_FUNC;
                    2'd1:    dbOut_d = INIT_DISP;
                    2'd2:    dbOut_d = INIT_ENTRY;
                    default: dbOut_d = INIT_CLEAR;
                endcase
            end
            2'd1:    dbOut_d = ddramCmd;
            2'd2:    dbOut_d = buffer_q[charPtr_q];
            default: dbOut_d = INIT_CLEAR;
        endcase
    end

    always_comb begin
        charPtr_d   = charPtr_q;
        lineWrap_d  = 1'b0;
        frameDone_d = 1'b0;
        if (advance) begin
            charPtr_d   = charPtr_q + 5'd1;
            lineWrap_d  = (charPtr_q[3:0] == 4'hF);
            frameDone_d = (charPtr_q == 5'd31);
        end else if (clearPtr) begin
            charPtr_d = 5'd0;
        end
    end

`ifdef LCD_BUSY_READ_EN
    always_comb begin
        dbOe_d = bus.DB_sel & ~bus.RW_out;
        busy_d = busy_q;
        if (bus.RW_out & ~bus.RS_out) begin
            dbOe_d = 1'b0;
        end
        if (bus.E_out & bus.RW_out) begin
            busy_d = bus.DB_in[7];
        end
    end
`else
    logic unusedDbIn;
    assign unusedDbIn = ^bus.DB_in;

    always_comb begin
        dbOe_d = bus.DB_sel & ~bus.RW_out;
        busy_d = 1'b0;
    end
`endif

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            charPtr_q   <= 5'd0;
            eOut_q      <= 1'b0;
            dbOut_q     <= 8'h00;
            dbOe_q      <= 1'b0;
            lineWrap_q  <= 1'b0;
            frameDone_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            charPtr_q   <= charPtr_d;
            eOut_q      <= bus.E_out;
            dbOut_q     <= dbOut_d;
            dbOe_q      <= dbOe_d;
            lineWrap_q  <= lineWrap_d;
            frameDone_q <= frameDone_d;
            busy_q      <= busy_d;
        end
    end

    // A write to the entry being displayed lands after DB_out has sampled the old value.
    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                buffer_q[i] <= FILL_CHAR;
            end
        end else if (bus.wr_en) begin
            buffer_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.DB_out     = dbOut_q;
    assign bus.DB_oe      = dbOe_q;
    assign bus.char_ptr   = charPtr_q;
    assign bus.line_wrap  = lineWrap_q;
    assign bus.frame_done = frameDone_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_lcd_datapath.sv
// Self-checking bench for lcd_datapath: directed checks plus randomized traffic
// compared every cycle against a behavioural display model.
module tb_lcd_datapath;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    lcd_datapath_if bus ();

    lcd_datapath dut (
        .clk_1ms (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of what the LCD bus and pointer should show.
    int         mPtr;
    logic [7:0] mBuf [32];
    bit         mEPrev;
    logic [7:0] mDb;
    bit         mOe;
    bit         mWrap;
    bit         mFrame;
    bit         mBusy;

    function automatic logic [7:0] initCmd(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] addrCmd(input int pos);
        if (pos < 16) return 8'(8'h80 + pos);
        return 8'(8'hC0 + (pos - 16));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mPtr   = 0;
            mEPrev = 0;
            mDb    = 8'h00;
            mOe    = 0;
            mWrap  = 0;
            mFrame = 0;
            mBusy  = 0;
            for (int i = 0; i < 32; i++) mBuf[i] = 8'h20;
        end else begin
            bit fell;
            fell = mEPrev && !bus.E_out;
            case (bus.mux_sel)
                2'd0:    mDb = initCmd(bus.init_sel);
                2'd1:    mDb = addrCmd(mPtr);
                2'd2:    mDb = mBuf[mPtr];
                default: mDb = 8'h01;
            endcase
            mOe = bus.DB_sel && !bus.RW_out;
`ifdef LCD_BUSY_READ_EN
            if (bus.RW_out && !bus.RS_out) mOe = 0;
            if (bus.E_out && bus.RW_out) mBusy = bus.DB_in[7];
`endif
            mWrap  = 0;
            mFrame = 0;
            if (fell && bus.data_sel && bus.RS_out && !bus.RW_out) begin
                mPtr   = (mPtr + 1) % 32;
                mWrap  = (mPtr % 16) == 0;
                mFrame = (mPtr == 0);
            end else if (fell && bus.mux_sel == 2'd3 && !bus.RS_out) begin
                mPtr = 0;
            end
            if (bus.wr_en) mBuf[bus.wr_addr] = bus.wr_data;
            mEPrev = bus.E_out;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    bit compareEn;

    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("model DB_out", bus.DB_out, mDb);
            checkOutput("model DB_oe", {7'd0, bus.DB_oe}, {7'd0, mOe});
            checkOutput("model char_ptr", {3'd0, bus.char_ptr}, 8'(mPtr));
            checkOutput("model line_wrap", {7'd0, bus.line_wrap}, {7'd0, mWrap});
            checkOutput("model frame_done", {7'd0, bus.frame_done}, {7'd0, mFrame});
            checkOutput("model busy", {7'd0, bus.busy}, {7'd0, mBusy});
        end
    end

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic ePulse();
        bus.E_out = 1'b1;
        applyStimulus(1);
        bus.E_out = 1'b0;
        applyStimulus(1);
    endtask

    int wrapHits;
    int frameHits;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        compareEn   = 0;
        reset       = 1'b1;
        bus.data_sel = 0; bus.DB_sel = 0; bus.init_sel = 0; bus.mux_sel = 0;
        bus.E_out = 0; bus.RW_out = 0; bus.RS_out = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.DB_in = 0;
        #1 reset = 1'b0;
        #1;
        checkOutput("reset DB_out", bus.DB_out, 8'h00);
        checkOutput("reset DB_oe", {7'd0, bus.DB_oe}, 8'h00);
        checkOutput("reset char_ptr", {3'd0, bus.char_ptr}, 8'h00);
        checkOutput("reset line_wrap", {7'd0, bus.line_wrap}, 8'h00);
        checkOutput("reset frame_done", {7'd0, bus.frame_done}, 8'h00);
        checkOutput("reset busy", {7'd0, bus.busy}, 8'h00);
        compareEn = 1;
        applyStimulus(2);
        reset = 1'b1;
        applyStimulus(1);

        bus.mux_sel = 2'd2;
        applyStimulus(1);
        checkOutput("fill char", bus.DB_out, 8'h20);

        bus.DB_sel  = 1'b1;
        bus.mux_sel = 2'd0;
        for (int s = 0; s < 4; s++) begin
            bus.init_sel = 2'(s);
            applyStimulus(1);
            checkOutput("init cmd", bus.DB_out, initCmd(2'(s)));
            checkOutput("init oe", {7'd0, bus.DB_oe}, 8'h01);
        end

        bus.wr_en = 1; bus.wr_addr = 5'd16; bus.wr_data = 8'h41;
        applyStimulus(1);
        bus.wr_en = 0;
        bus.mux_sel = 2'd2; bus.data_sel = 1; bus.RS_out = 1;
        for (int p = 0; p < 16; p++) ePulse();
        checkOutput("ptr after 16", {3'd0, bus.char_ptr}, 8'd16);
        checkOutput("wrap at 16", {7'd0, bus.line_wrap}, 8'h01);
        bus.data_sel = 0; bus.RS_out = 0;
        bus.mux_sel = 2'd1;
        applyStimulus(1);
        checkOutput("ddram line2", bus.DB_out, 8'hC0);
        checkOutput("wrap one cycle", {7'd0, bus.line_wrap}, 8'h00);
        bus.mux_sel = 2'd2;
        applyStimulus(1);
        checkOutput("buffer line2", bus.DB_out, 8'h41);

        bus.mux_sel = 2'd3;
        ePulse();
        checkOutput("clear ptr", {3'd0, bus.char_ptr}, 8'h00);
        checkOutput("clear no wrap", {7'd0, bus.line_wrap}, 8'h00);

        bus.mux_sel = 2'd2; bus.data_sel = 1; bus.RS_out = 1;
        wrapHits = 0; frameHits = 0;
        for (int p = 0; p < 32; p++) begin
            ePulse();
            if (bus.line_wrap) wrapHits++;
            if (bus.frame_done) frameHits++;
            if (p == 15) checkOutput("no frame at 16", {7'd0, bus.frame_done}, 8'h00);
            if (p == 31) checkOutput("frame at 32", {7'd0, bus.frame_done}, 8'h01);
        end
        checkOutput("wrap count", 8'(wrapHits), 8'd2);
        checkOutput("frame count", 8'(frameHits), 8'd1);
        checkOutput("ptr back to 0", {3'd0, bus.char_ptr}, 8'h00);
        bus.data_sel = 0; bus.RS_out = 0;

        applyStimulus(1);
        bus.wr_en = 1; bus.wr_addr = 5'd0; bus.wr_data = 8'h5A;
        applyStimulus(1);
        checkOutput("collision old", bus.DB_out, 8'h20);
        bus.wr_en = 0;
        applyStimulus(1);
        checkOutput("collision new", bus.DB_out, 8'h5A);

        bus.mux_sel = 2'd0; bus.init_sel = 2'd0; bus.E_out = 1;
        applyStimulus(1);
        checkOutput("pre-reset oe", {7'd0, bus.DB_oe}, 8'h01);
        #2 reset = 1'b0;
        #1;
        checkOutput("async DB_oe", {7'd0, bus.DB_oe}, 8'h00);
        checkOutput("async DB_out", bus.DB_out, 8'h00);
        checkOutput("async char_ptr", {3'd0, bus.char_ptr}, 8'h00);
        applyStimulus(1);
        reset = 1'b1; bus.E_out = 0; bus.mux_sel = 2'd2;
        applyStimulus(1);
        checkOutput("buffer refilled", bus.DB_out, 8'h20);

        bus.RW_out = 1; bus.RS_out = 0; bus.E_out = 1; bus.DB_in = 8'h80;
        applyStimulus(1);
`ifdef LCD_BUSY_READ_EN
        checkOutput("busy set", {7'd0, bus.busy}, 8'h01);
`else
        checkOutput("busy tied", {7'd0, bus.busy}, 8'h00);
`endif
        checkOutput("read oe", {7'd0, bus.DB_oe}, 8'h00);
        bus.DB_in = 8'h00;
        applyStimulus(1);
        checkOutput("busy clear", {7'd0, bus.busy}, 8'h00);
        bus.RW_out = 0; bus.E_out = 0;
        applyStimulus(1);

        for (int c = 0; c < 600; c++) begin
            bus.E_out    = 1'($urandom_range(0, 1));
            bus.data_sel = ($urandom_range(0, 3) != 0);
            bus.RS_out   = ($urandom_range(0, 3) != 0);
            bus.RW_out   = ($urandom_range(0, 5) == 0);
            bus.DB_sel   = 1'($urandom_range(0, 1));
            bus.mux_sel  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bus.init_sel = 2'($urandom_range(0, 3));
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = 5'($urandom_range(0, 31));
            bus.wr_data  = 8'($urandom);
            bus.DB_in    = 8'($urandom);
            applyStimulus(1);
        end

        compareEn = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
